// File: rtl/led_pattern_gen_if.sv
// LED pattern generator control/status bundle: enable and mode in, LED drive and tick out.
interface led_pattern_gen_if #(
  parameter int unsigned N_LEDS = 4
);
  logic              en;
  logic [1:0]        mode;
  logic [N_LEDS-1:0] led;
  logic              tick;

  modport master (output en, output mode, input led, input tick);
  modport slave  (input en, input mode, output led, output tick);
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: blink, binary count, chase and PWM breathe
// patterns advanced on each prescaler wrap, with enable/freeze and runtime mode select.
module led_pattern_gen #(
  parameter int unsigned          CNT_WIDTH = 24,
  parameter logic [CNT_WIDTH-1:0] INIT      = '0,
  parameter int unsigned          N_LEDS    = 4,
  parameter int unsigned          PWM_BITS  = 4
) (
  input logic             clk,
  input logic             rst,
  led_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    BLINK   = 2'd0,
    COUNT   = 2'd1,
    CHASE   = 2'd2,
    BREATHE = 2'd3
  } mode_e;

  logic [CNT_WIDTH-1:0] cnt;
  logic                 blink;
  logic [N_LEDS-1:0]    step;
  logic [N_LEDS-1:0]    chase;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  duty;
  logic                 duty_up;
  mode_e                mode_q;

  logic                 wrap;
  logic                 mode_chg;
  logic                 duty_up_nxt;
  logic [PWM_BITS-1:0]  duty_nxt;
  logic [N_LEDS-1:0]    led_nxt;

  // Wrap detect, triangle duty stepping and pattern decode of the current state.
  always_comb begin
    wrap        = 1'b0;
    mode_chg    = 1'b0;
    duty_up_nxt = duty_up;
    duty_nxt    = duty;
    led_nxt     = '0;

    wrap     = bus.en && (cnt == '1);
    mode_chg = (mode_e'(bus.mode) != mode_q);

    // Direction flips at the endpoints so each endpoint is visited only once.
    duty_up_nxt = duty_up ? (duty != '1) : (duty == '0);
    duty_nxt    = duty_up_nxt ? duty + PWM_BITS'(1) : duty - PWM_BITS'(1);

    unique case (mode_q)
      BLINK:   led_nxt = {N_LEDS{blink}};
      COUNT:   led_nxt = step;
      CHASE:   led_nxt = chase;
      BREATHE: led_nxt = {N_LEDS{pwm_cnt < duty}};
      default: led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= INIT;
      bus.tick <= 1'b0;
      bus.led  <= '0;
      blink    <= 1'b0;
      step     <= '0;
      chase    <= N_LEDS'(1);
      pwm_cnt  <= '0;
      duty     <= '0;
      duty_up  <= 1'b1;
      mode_q   <= BLINK;
    end else begin
      mode_q   <= mode_e'(bus.mode);
      bus.tick <= wrap;

      if (bus.en) begin
        cnt     <= cnt + CNT_WIDTH'(1);
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        bus.led <= led_nxt;
      end

      // A mode change restarts the pattern and takes priority over a coincident wrap.
      if (mode_chg) begin
        blink   <= 1'b0;
        step    <= '0;
        chase   <= N_LEDS'(1);
        pwm_cnt <= '0;
        duty    <= '0;
        duty_up <= 1'b1;
      end else if (wrap) begin
        blink   <= ~blink;
        step    <= step + N_LEDS'(1);
        chase   <= {chase[N_LEDS-2:0], chase[N_LEDS-1]};
        duty    <= duty_nxt;
        duty_up <= duty_up_nxt;
      end
    end
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the single-counter LED blinker.
- A free-running prescaler with a programmable start value generates a periodic tick. The tick drives one of four selectable LED patterns across N_LEDS outputs: blink, binary count, chase, and PWM breathe.
- Sits between the board clock and the LED pins in top-level board designs.
- Adds the following to the old blinker: enable/freeze, runtime mode select, and PWM dimming.

Parameters:
CNT_WIDTH, 24, prescaler width; tick period is 2^CNT_WIDTH enabled cycles after the first wrap.
INIT, {CNT_WIDTH{1'b0}}, prescaler value loaded at reset; first tick arrives after (2^CNT_WIDTH - INIT) enabled cycles.
N_LEDS, 4, number of LED outputs (>=2).
PWM_BITS, 4, PWM counter/duty width for breathe mode (>=2).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; when low, all state and outputs hold.
mode  input  2  pattern select: 0 BLINK, 1 COUNT, 2 CHASE, 3 BREATHE.
led  output  N_LEDS  registered LED drive, active-high.
tick  output  1  registered one-cycle pulse on prescaler wrap.

Behaviour:
- Reset values:
  - prescaler cnt = INIT; tick = 0; led = 0.
  - blink flag = 0; step counter = 0; chase = 1 (bit0 set).
  - pwm_cnt = 0; duty = 0; duty direction = up; mode_q = 0.
- Prescaler: when en=1, cnt <= cnt+1 (modulo 2^CNT_WIDTH).
- Wrap condition W = en & (cnt == all-ones).
  - tick <= W, so tick is high for exactly one cycle, on the edge after cnt reaches all-ones.
  - After a wrap, cnt restarts from 0, not INIT.
- Pattern state updates on the same edge that registers tick, i.e. when W is true:
  - blink flag toggles.
  - step increments, wrapping 2^N_LEDS-1 -> 0.
  - chase rotates left, MSB -> bit0.
  - duty steps by 1 toward its limit. It reverses direction on reaching max (2^PWM_BITS-1) or 0, so the sequence is 0,1,..,max,max-1,..,0,1,...
  - Endpoints are held for one tick each and are not repeated.
- pwm_cnt increments on every cycle with en=1, independent of tick, and wraps.
- led is registered from the current state on every edge with en=1, so led lags the state by 1 cycle:
  - BLINK: all bits = blink flag.
  - COUNT: led = step.
  - CHASE: led = chase.
  - BREATHE: all bits = (pwm_cnt < duty). duty=0 gives constant off; duty=max gives on for max/2^PWM_BITS of the PWM period.
- Mode change:
  - mode is registered into mode_q each cycle, regardless of en.
  - When mode != mode_q, pattern state is reinitialised on that edge (flag 0, step 0, chase 1, duty 0/up, pwm_cnt 0). The prescaler is not reset.
  - If W coincides with a mode change, reinitialisation wins.
  - led shows the new mode's initial pattern on the next enabled edge.
- en=0: cnt, tick (forced 0), pattern state, pwm_cnt and led all freeze.
  - A wrap cannot occur while en=0.
  - Resuming continues the sequence exactly where it stopped.
- rst asserted mid-operation: all registers return to reset values on that edge, overriding en and mode.
- Widths:
  - INIT is truncated to CNT_WIDTH.
  - All counters wrap silently; no saturation except duty, which reverses direction.

Test Plan:
1. CNT_WIDTH=4, INIT=4'hA, mode=0, en=1 after rst:
   - tick pulses after the 6th edge, then every 16 cycles.
   - led toggles 0000 -> 1111 one cycle after each tick.
2. Same bench, mode=1:
   - led sequence over successive ticks is 1, 2, …, 15, 0.
   - tick is exactly 1 cycle wide every time.
3. Mode=2:
   - led sequence over successive ticks is 0001, 0010, 0100, 1000, 0001.
   - Switching to mode=1 mid-run gives led=0000 on the next enabled edge, then 0001 after the following tick.
4. Mode=3 with PWM_BITS=2:
   - duty over ticks is 0,1,2,3,2,1,0,1.
   - With duty=2, led is high exactly 2 of every 4 cycles; with duty=0, led is always 0.
5. en deasserted for 20 cycles mid-period:
   - cnt, led and tick are frozen.
   - After re-enable, the next tick arrives exactly the remaining-count cycles later.
6. rst pulsed for one cycle during CHASE with led=0100:
   - next cycle shows led=0, tick=0, cnt=INIT.
   - The first tick arrives again 6 cycles after rst release.
